// File: rtl/ccrf_job_ingress.sv
// ccrf_job_ingress
//
// Reassembles multi-beat job descriptors from a narrow AXI-Stream slave.
// Job 0 programs the scratchpad window. Every other job is validated and,
// if it is legal, queued in a DEPTH-entry FIFO for the scheduler. Each
// descriptor produces exactly one 64-bit status message on the response
// stream.
//
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   s_job_t{valid,ready,data,last}
//                             descriptor beats; beat k carries bits [k*IN_W +: IN_W]
//   m_job_t{valid,ready,data} queued descriptors to the scheduler (FIFO head)
//   rsp_t{valid,ready,data}   status: [7:0] job_id, [15:8] status,
//                             [31:16] FIFO occupancy after the event, [63:32] zero
//   scratch_start/end/valid   programmed scratchpad window
module ccrf_job_ingress #(
  parameter int IN_W       = 64,
  parameter int JOB_W      = 576,
  parameter int DEPTH      = 4,
  parameter int MAX_IMAGES = 5
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_job_tvalid,
  output logic              s_job_tready,
  input  logic [IN_W-1:0]   s_job_tdata,
  input  logic              s_job_tlast,
  output logic              m_job_tvalid,
  input  logic              m_job_tready,
  output logic [JOB_W-1:0]  m_job_tdata,
  output logic              rsp_tvalid,
  input  logic              rsp_tready,
  output logic [63:0]       rsp_tdata,
  output logic [63:0]       scratch_start,
  output logic [63:0]       scratch_end,
  output logic              scratch_valid
);

  localparam int BEATS = JOB_W / IN_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);
  localparam logic [7:0]       MAX_COUNT = 8'(MAX_IMAGES);

  localparam logic [7:0] ST_ACCEPT      = 8'd0;
  localparam logic [7:0] ST_SCRATCH_SET = 8'd1;
  localparam logic [7:0] ST_BAD_COUNT   = 8'd2;
  localparam logic [7:0] ST_NO_SCRATCH  = 8'd3;
  localparam logic [7:0] ST_FRAME_ERR   = 8'd4;
  localparam logic [7:0] ST_RANGE_ERR   = 8'd5;

  typedef enum logic [1:0] {COLLECT, DRAIN, DECIDE, RESPOND} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             frame_err_reg, frame_err_next;
  logic [63:0]      rsp_data_reg;
  logic [63:0]      scratch_start_reg, scratch_end_reg;
  logic             scratch_valid_reg;

  logic             capture;
  logic             clear_desc;
  logic             need_push;
  logic             decide_done;
  logic [7:0]       status;
  logic             push, pop;
  logic             load_window;

  // ---------------------------------------------------------------
  // Descriptor assembly: one register per beat, all cleared together
  // whenever the FSM re-enters COLLECT, so bits of a truncated frame
  // that never arrived read as zero.
  // ---------------------------------------------------------------
  logic [JOB_W-1:0] desc;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    logic [IN_W-1:0] beat_reg;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        beat_reg <= '0;
      end else if (clear_desc) begin
        beat_reg <= '0;
      end else if (capture && cnt_reg == CNT_W'(gi)) begin
        beat_reg <= s_job_tdata;
      end
    end
    assign desc[gi*IN_W +: IN_W] = beat_reg;
  end

  logic [7:0]  job_id;
  logic [63:0] win_start, win_end;
  logic [7:0]  img_count;

  assign job_id    = desc[519:512];
  assign win_start = desc[127:64];
  assign win_end   = desc[191:128];
  assign img_count = desc[487:480];

  // ---------------------------------------------------------------
  // Job FIFO. Storage has no reset; the head is forced to zero while
  // empty so stale entries never appear on m_job_tdata.
  // ---------------------------------------------------------------
  logic [JOB_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             fifo_empty, fifo_full;

  assign fifo_empty   = (occ_reg == '0);
  assign fifo_full    = (occ_reg == FULL_OCC);
  assign m_job_tvalid = !fifo_empty;
  assign m_job_tdata  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
  assign pop          = m_job_tvalid && m_job_tready;
  assign push         = decide_done && need_push;

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= desc;
    end
  end

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      occ_reg <= occ_next;
    end
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  logic s_ready_int;

  // Ready is masked by reset so the port reads 0 while areset is held.
  assign s_ready_int  = (state_reg == COLLECT) || (state_reg == DRAIN);
  assign s_job_tready = s_ready_int && !areset;
  assign capture      = (state_reg == COLLECT) && s_job_tvalid;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    frame_err_next = frame_err_reg;
    clear_desc     = 1'b0;
    status         = ST_ACCEPT;
    need_push      = 1'b0;
    decide_done    = 1'b0;

    case (state_reg)
      COLLECT: begin
        if (s_job_tvalid) begin
          if (s_job_tlast) begin
            state_next     = DECIDE;
            frame_err_next = (cnt_reg != LAST_BEAT);
            cnt_next       = '0;
          end else if (cnt_reg == LAST_BEAT) begin
            // Frame longer than a descriptor: swallow the rest.
            state_next     = DRAIN;
            frame_err_next = 1'b1;
            cnt_next       = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (s_job_tvalid && s_job_tlast) begin
          state_next = DECIDE;
        end
      end

      DECIDE: begin
        if (frame_err_reg) begin
          status = ST_FRAME_ERR;
        end else if (job_id == 8'd0) begin
          status = (win_end <= win_start) ? ST_RANGE_ERR : ST_SCRATCH_SET;
        end else if (!scratch_valid_reg) begin
          status = ST_NO_SCRATCH;
        end else if (img_count == 8'd0 || img_count > MAX_COUNT) begin
          status = ST_BAD_COUNT;
        end else begin
          status    = ST_ACCEPT;
          need_push = 1'b1;
        end
        // A full FIFO only blocks us unless the scheduler frees a slot
        // in this very cycle.
        if (!need_push || !fifo_full || pop) begin
          decide_done = 1'b1;
          state_next  = RESPOND;
        end
      end

      RESPOND: begin
        if (rsp_tready) begin
          state_next     = COLLECT;
          cnt_next       = '0;
          frame_err_next = 1'b0;
          clear_desc     = 1'b1;
        end
      end

      default: state_next = COLLECT;
    endcase
  end

  assign load_window = decide_done && (status == ST_SCRATCH_SET);

  // ---------------------------------------------------------------
  // Response and scratchpad window registers
  // ---------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rsp_data_reg      <= '0;
      scratch_start_reg <= '0;
      scratch_end_reg   <= '0;
      scratch_valid_reg <= 1'b0;
    end else begin
      if (decide_done) begin
        rsp_data_reg <= {32'h0, 16'(occ_next), status, job_id};
      end
      if (load_window) begin
        scratch_start_reg <= win_start;
        scratch_end_reg   <= win_end;
        scratch_valid_reg <= 1'b1;
      end
    end
  end

  assign rsp_tvalid    = (state_reg == RESPOND);
  assign rsp_tdata     = rsp_data_reg;
  assign scratch_start = scratch_start_reg;
  assign scratch_end   = scratch_end_reg;
  assign scratch_valid = scratch_valid_reg;

endmodule
